// File: rtl/aes_rcon_pkg.sv
// Shared AES round-constant definitions: initial value, reduction polynomial,
// forward/inverse GF(2^8) doubling steps, schedule-end constant and sequencer states.
// Pure declarations; no logic or state of its own.
package aes_rcon_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rcon_state_e;

    // Multiply by x in GF(2^8), reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] rcon_fwd(input logic [7:0] r);
        logic [7:0] sh;
        sh = {r[6:0], 1'b0};
        return r[7] ? (sh ^ RCON_POLY) : sh;
    endfunction

    // Divide by x: an odd value had the polynomial folded in, so undo it and
    // restore the bit that was shifted out of position 7.
    function automatic logic [7:0] rcon_inv(input logic [7:0] r);
        return r[0] ? (((r ^ RCON_POLY) >> 1) | 8'h80) : (r >> 1);
    endfunction

    // Final rcon of a schedule of nrcon values; used at elaboration time only.
    function automatic logic [7:0] rcon_last(input int nrcon);
        logic [7:0] r;
        r = RCON_INIT;
        for (int i = 1; i < nrcon; i++) begin
            r = rcon_fwd(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/MSKcst.sv
// Turns a public constant into a trivial d-share sharing (value, 0, ..., 0).
// Latency: combinational, zero cycles.
// Backpressure: none; pure wiring.
// Ports: in_dat  - count-bit constant
//        sh_out  - count*d bits, share 0 in [count-1:0], higher shares zero
module MSKcst #(
    parameter int d     = 2,
    parameter int count = 8
) (
    input  logic [count-1:0]   in_dat,
    output logic [count*d-1:0] sh_out
);

    // The value is public, so no randomness is needed: the extra shares are zero.
    assign sh_out = {{(count*(d-1)){1'b0}}, in_dat};

endmodule

// File: rtl/mskaes_rcon_seq.sv
// Sequenced AES round-constant generator (forward/inverse), masked d-share output.
// Latency: new rcon one cycle after start/update; sh_rcon follows mask_rcon combinationally.
// Backpressure: none; update advances immediately, start aborts and reloads.
// Ports: clk, rst_n (async, active low); start, inverse, update, mask_rcon inputs;
//        sh_rcon (8*d shared rcon), busy, last, done (one-cycle pulse after final value).
module mskaes_rcon_seq
    import aes_rcon_pkg::*;
#(
    parameter int d     = 2,
    parameter int NRCON = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inverse,
    input  logic             update,
    input  logic             mask_rcon,
    output logic [8*d-1:0]   sh_rcon,
    output logic             busy,
    output logic             last,
    output logic             done
);

    localparam int             IW        = $clog2(NRCON);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NRCON - 1);
    localparam logic [7:0]     RCON_LAST = rcon_last(NRCON);

    rcon_state_e    state_q, state_d;
    logic [7:0]     rcon_q,  rcon_d;
    logic [IW-1:0]  idx_q,   idx_d;
    logic           dir_q,   dir_d;
    logic           done_q,  done_d;
    logic [7:0]     rcon_gated;

    always_comb begin
        state_d = state_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        // start wins over update in either state; in RUN it is an abort without done.
        if (start) begin
            state_d = ST_RUN;
            rcon_d  = inverse ? RCON_LAST : RCON_INIT;
            idx_d   = '0;
            dir_d   = inverse;
        end else if (state_q == ST_RUN && update) begin
            if (idx_q == IDX_LAST) begin
                state_d = ST_IDLE;
                rcon_d  = RCON_INIT;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                rcon_d  = dir_q ? rcon_inv(rcon_q) : rcon_fwd(rcon_q);
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rcon_q  <= RCON_INIT;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign last = busy & (idx_q == IDX_LAST);
    assign done = done_q;

    // Gating with busy keeps the output zero in IDLE even though rcon holds 01 there.
    assign rcon_gated = rcon_q & {8{mask_rcon & busy}};

    MSKcst #(
        .d     (d),
        .count (8)
    ) u_mskcst (
        .in_dat (rcon_gated),
        .sh_out (sh_rcon)
    );

endmodule

// File: tb/tb_mskaes_rcon_seq.sv
module tb_mskaes_rcon_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        inverse = 1'b0;
    logic        update = 1'b0;
    logic        mask_rcon = 1'b1;
    logic [15:0] sh10, sh7;
    logic        busy10, last10, done10;
    logic        busy7, last7, done7;

    always #5 clk = ~clk;

    mskaes_rcon_seq #(.d(2), .NRCON(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
        .update(update), .mask_rcon(mask_rcon),
        .sh_rcon(sh10), .busy(busy10), .last(last10), .done(done10)
    );

    mskaes_rcon_seq #(.d(2), .NRCON(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
        .update(update), .mask_rcon(mask_rcon),
        .sh_rcon(sh7), .busy(busy7), .last(last7), .done(done7)
    );

    typedef struct packed {
        logic       busy;
        logic       last;
        logic [7:0] val;
    } exp_t;

    exp_t q10[$];
    exp_t q7[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Forward AES round constants; the inverse schedule reads this backwards.
    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic inv);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.busy = 1'b1;
            e.last = (i == 9);
            e.val  = inv ? rc_tab[9-i] : rc_tab[i];
            q10.push_back(e);
            if (i < 7) begin
                e.busy = 1'b1;
                e.last = (i == 6);
                e.val  = inv ? rc_tab[6-i] : rc_tab[i];
            end else begin
                e = '0;
            end
            q7.push_back(e);
        end
    endtask

    task automatic do_start(input logic inv, input logic with_upd);
        @(negedge clk);
        start   = 1'b1;
        inverse = inv;
        update  = with_upd;
        @(negedge clk);
        start   = 1'b0;
        update  = 1'b0;
        inverse = ~inv;
    endtask

    // mmode 0: mask always on; 1: mask alternates each cycle.
    task automatic run_updates(input int n, input int mmode);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            update    = 1'b1;
            mask_rcon = (mmode == 0) ? 1'b1 : ((k % 2) == 0);
            inverse   = 1'($urandom_range(0, 1));
            #1;
            if (q10.size() == 0 || q7.size() == 0) begin
                chk_eq("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q10.pop_front();
                chk_eq("n10_share0", {24'h0, sh10[7:0]}, {24'h0, (mask_rcon ? e.val : 8'h00)});
                chk_eq("n10_share1", {24'h0, sh10[15:8]}, 32'd0);
                chk_eq("n10_busy", {31'h0, busy10}, {31'h0, e.busy});
                chk_eq("n10_last", {31'h0, last10}, {31'h0, e.last});
                chk_eq("n10_done_mid", {31'h0, done10}, 32'd0);
                e = q7.pop_front();
                chk_eq("n7_share0", {24'h0, sh7[7:0]}, {24'h0, (mask_rcon ? e.val : 8'h00)});
                chk_eq("n7_share1", {24'h0, sh7[15:8]}, 32'd0);
                chk_eq("n7_busy", {31'h0, busy7}, {31'h0, e.busy});
                chk_eq("n7_last", {31'h0, last7}, {31'h0, e.last});
                chk_eq("n7_done", {31'h0, done7}, {31'h0, (k == 7)});
            end
            @(negedge clk);
        end
        update    = 1'b0;
        mask_rcon = 1'b1;
    endtask

    task automatic check_tail();
        #1;
        chk_eq("n10_done_pulse", {31'h0, done10}, 32'd1);
        chk_eq("n10_busy_end", {31'h0, busy10}, 32'd0);
        chk_eq("n10_sh_end", {16'h0, sh10}, 32'd0);
        chk_eq("n7_done_late", {31'h0, done7}, 32'd0);
        @(negedge clk);
        #1;
        chk_eq("n10_done_once", {31'h0, done10}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_busy", {31'h0, busy10}, 32'd0);
        chk_eq("rst_last", {31'h0, last10}, 32'd0);
        chk_eq("rst_done", {31'h0, done10}, 32'd0);
        chk_eq("rst_sh", {16'h0, sh10}, 32'd0);
        chk_eq("rst_busy7", {31'h0, busy7}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // update in IDLE must not start anything
        update = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_eq("idle_upd_busy", {31'h0, busy10}, 32'd0);
            chk_eq("idle_upd_done", {31'h0, done10}, 32'd0);
            chk_eq("idle_upd_sh", {16'h0, sh10}, 32'd0);
        end
        update = 1'b0;

        // forward schedule, mask on
        do_start(1'b0, 1'b0);
        push_exp(1'b0);
        run_updates(10, 0);
        check_tail();

        // inverse schedule, mask toggling
        do_start(1'b1, 1'b0);
        push_exp(1'b1);
        run_updates(10, 1);
        check_tail();

        // restart at idx 5 with a simultaneous update: reload, no done
        do_start(1'b0, 1'b0);
        push_exp(1'b0);
        run_updates(5, 0);
        q10.delete();
        q7.delete();
        do_start(1'b1, 1'b1);
        #1;
        chk_eq("restart_done10", {31'h0, done10}, 32'd0);
        chk_eq("restart_done7", {31'h0, done7}, 32'd0);
        push_exp(1'b1);
        run_updates(10, 0);
        check_tail();

        // async reset at idx 4
        do_start(1'b0, 1'b0);
        push_exp(1'b0);
        run_updates(4, 0);
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_busy", {31'h0, busy10}, 32'd0);
        chk_eq("midrst_sh", {16'h0, sh10}, 32'd0);
        chk_eq("midrst_last", {31'h0, last10}, 32'd0);
        chk_eq("midrst_busy7", {31'h0, busy7}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q10.delete();
        q7.delete();
        #1;
        chk_eq("postrst_busy", {31'h0, busy10}, 32'd0);
        chk_eq("postrst_done", {31'h0, done10}, 32'd0);
        do_start(1'b0, 1'b0);
        push_exp(1'b0);
        run_updates(10, 0);
        check_tail();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
